// File: rtl/qsfp_link_monitor.sv
// qsfp_link_monitor: synchronise, debounce and count drops of two Aurora channel_up flags
module qsfp_link_monitor #(
  parameter int UP_CYCLES   = 1000,
  parameter int DOWN_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qsfp0_channel_up_raw,
  input  logic             qsfp1_channel_up_raw,
  input  logic             clear_stats,
  output logic             ss0_channel_up,
  output logic             ss1_channel_up,
  output logic [CNT_W-1:0] ss0_drop_count,
  output logic [CNT_W-1:0] ss1_drop_count,
  output logic             ss0_lost,
  output logic             ss1_lost
);
  typedef enum logic [1:0] {DOWN, QUAL_UP, UP, QUAL_DOWN} state_t;
  logic [1:0] raw, up, lost;
  logic [CNT_W-1:0] cnt [2];
  assign raw = {qsfp1_channel_up_raw, qsfp0_channel_up_raw};
  for (genvar i = 0; i < 2; i++) begin : g_lane
    state_t st, st_n;
    logic [31:0] tmr, tmr_n;
    logic [1:0] sync;
    logic s, drop, lost_r;
    logic [CNT_W-1:0] cnt_r;
    assign s = sync[1];
    always_ff @(posedge clk)
      if (reset) begin
        sync <= 2'b00;
        st   <= DOWN;
        tmr  <= 32'd0;
      end else begin
        sync <= {sync[0], raw[i]};
        st   <= st_n;
        tmr  <= tmr_n;
      end
    always_comb begin
      st_n  = st;
      tmr_n = tmr;
      drop  = 1'b0;
      case (st)
        DOWN:
          if (s) begin
            st_n  = QUAL_UP;
            tmr_n = 32'd1;
          end
        QUAL_UP:
          if (!s) st_n = DOWN;
          else if (tmr == 32'(UP_CYCLES)) st_n = UP;
          else tmr_n = tmr + 32'd1;
        UP:
          if (!s) begin
            st_n  = QUAL_DOWN;
            tmr_n = 32'd1;
          end
        QUAL_DOWN:
          if (s) st_n = UP;
          else if (tmr == 32'(DOWN_CYCLES)) begin
            st_n = DOWN;
            drop = 1'b1;
          end else tmr_n = tmr + 32'd1;
        default: st_n = DOWN;
      endcase
    end
    // a drop on the same edge as clear_stats wins and counts as the first drop
    always_ff @(posedge clk)
      if (reset) begin
        cnt_r  <= '0;
        lost_r <= 1'b0;
      end else if (drop) begin
        cnt_r  <= clear_stats ? CNT_W'(1) : cnt_r + CNT_W'(~&cnt_r);
        lost_r <= 1'b1;
      end else if (clear_stats) begin
        cnt_r  <= '0;
        lost_r <= 1'b0;
      end
    assign up[i]   = st == UP || st == QUAL_DOWN;
    assign lost[i] = lost_r;
    assign cnt[i]  = cnt_r;
  end
  assign ss0_channel_up = up[0];
  assign ss1_channel_up = up[1];
  assign ss0_drop_count = cnt[0];
  assign ss1_drop_count = cnt[1];
  assign ss0_lost       = lost[0];
  assign ss1_lost       = lost[1];
endmodule

// File: tb/tb_qsfp_link_monitor.sv
// tb_qsfp_link_monitor: directed and randomised checks against a run-length reference model
module tb_qsfp_link_monitor;
  localparam int UP = 8;
  localparam int DN = 4;
  localparam int W  = 4;
  logic clk = 1'b0, reset = 1'b1, raw0 = 1'b0, raw1 = 1'b0, clear_stats = 1'b0;
  logic ss0_channel_up, ss1_channel_up, ss0_lost, ss1_lost;
  logic [W-1:0] ss0_drop_count, ss1_drop_count;
  logic [13:0] obs;
  int pass_cnt = 0, total = 0;
  // model: stable level, run of disagreeing synced samples, stats, 2-stage input delay
  int ml[2], mr[2], mc[2], mlost[2], m1[2], m2[2];

  qsfp_link_monitor #(.UP_CYCLES(UP), .DOWN_CYCLES(DN), .CNT_W(W)) dut (
    .clk(clk), .reset(reset),
    .qsfp0_channel_up_raw(raw0), .qsfp1_channel_up_raw(raw1),
    .clear_stats(clear_stats),
    .ss0_channel_up(ss0_channel_up), .ss1_channel_up(ss1_channel_up),
    .ss0_drop_count(ss0_drop_count), .ss1_drop_count(ss1_drop_count),
    .ss0_lost(ss0_lost), .ss1_lost(ss1_lost));

  assign obs = {ss1_channel_up, ss0_channel_up, ss1_drop_count, ss0_drop_count, ss1_lost, ss0_lost};
  always #5 clk = ~clk;

  function automatic void model_edge();
    int rv[2];
    rv[0] = int'(raw0);
    rv[1] = int'(raw1);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ml[i] = 0; mr[i] = 0; mc[i] = 0; mlost[i] = 0; m1[i] = 0; m2[i] = 0;
      end else begin
        bit dropped = 0;
        mr[i] = (m2[i] != ml[i]) ? mr[i] + 1 : 0;
        if (mr[i] == (ml[i] != 0 ? DN : UP) + 1) begin
          dropped = (ml[i] != 0);
          ml[i] = 1 - ml[i];
          mr[i] = 0;
        end
        if (dropped) begin
          mc[i] = clear_stats ? 1 : (mc[i] < (1 << W) - 1 ? mc[i] + 1 : mc[i]);
          mlost[i] = 1;
        end else if (clear_stats) begin
          mc[i] = 0; mlost[i] = 0;
        end
        m2[i] = m1[i];
        m1[i] = rv[i];
      end
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    return {1'(ml[1]), 1'(ml[0]), W'(mc[1]), W'(mc[0]), 1'(mlost[1]), 1'(mlost[0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      total++;
      if (obs !== 14'd0) $display("FAIL reset_state got %h expected %h", obs, 14'd0);
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rise_latency();
    raw0 = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      total++;
      if (ss0_channel_up !== (e >= 10) || ss1_channel_up !== 1'b0)
        $display("FAIL rise_latency edge %0d got up0=%b up1=%b expected up0=%b up1=0", e, ss0_channel_up, ss1_channel_up, e >= 10);
      else pass_cnt++;
      total++;
      if (obs !== exp_vec()) $display("FAIL rise_model edge %0d got %h expected %h", e, obs, exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 8; e++) begin
      raw0 = (e >= 3);
      tick();
      total++;
      if (ss0_channel_up !== 1'b1) $display("FAIL glitch_up edge %0d got %b expected 1", e, ss0_channel_up);
      else pass_cnt++;
    end
    total++;
    if (ss0_drop_count !== 4'd0 || ss0_lost !== 1'b0)
      $display("FAIL glitch_stats got cnt=%0d lost=%b expected cnt=0 lost=0", ss0_drop_count, ss0_lost);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    raw0 = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      total++;
      if (ss0_channel_up !== (e < 6)) $display("FAIL drop_latency edge %0d got %b expected %b", e, ss0_channel_up, e < 6);
      else pass_cnt++;
    end
    total++;
    if (ss0_drop_count !== 4'd1 || ss0_lost !== 1'b1)
      $display("FAIL drop_stats got cnt=%0d lost=%b expected cnt=1 lost=1", ss0_drop_count, ss0_lost);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 20; n++)
      for (int e = 0; e < 20; e++) begin
        raw1 = (e < 12);
        tick();
        total++;
        if (obs !== exp_vec()) $display("FAIL saturate_model round %0d edge %0d got %h expected %h", n, e, obs, exp_vec());
        else pass_cnt++;
      end
    total++;
    if (ss1_drop_count !== 4'd15 || ss1_lost !== 1'b1)
      $display("FAIL saturate_count got cnt=%0d lost=%b expected cnt=15 lost=1", ss1_drop_count, ss1_lost);
    else pass_cnt++;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    tick();
    total++;
    if (ss1_drop_count !== 4'd0 || ss1_lost !== 1'b0 || ss0_drop_count !== 4'd0 || ss0_lost !== 1'b0)
      $display("FAIL clear_stats got cnt1=%0d lost1=%b cnt0=%0d lost0=%b expected all 0", ss1_drop_count, ss1_lost, ss0_drop_count, ss0_lost);
    else pass_cnt++;
  endtask

  task automatic test_clear_coincide();
    for (int e = 0; e < 20; e++) begin
      raw0 = (e < 12);
      tick();
    end
    raw0 = 1'b1;
    for (int e = 0; e < 12; e++) tick();
    total++;
    if (ss0_drop_count !== 4'd1 || ss0_channel_up !== 1'b1)
      $display("FAIL coincide_setup got cnt=%0d up=%b expected cnt=1 up=1", ss0_drop_count, ss0_channel_up);
    else pass_cnt++;
    raw0 = 1'b0;
    for (int e = 0; e < 7; e++) begin
      clear_stats = (e == 6);
      tick();
    end
    clear_stats = 1'b0;
    total++;
    if (ss0_drop_count !== 4'd1 || ss0_lost !== 1'b1 || ss0_channel_up !== 1'b0)
      $display("FAIL clear_coincide got cnt=%0d lost=%b up=%b expected cnt=1 lost=1 up=0", ss0_drop_count, ss0_lost, ss0_channel_up);
    else pass_cnt++;
    total++;
    if (obs !== exp_vec()) $display("FAIL coincide_model got %h expected %h", obs, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    raw0 = 1'b1;
    for (int e = 0; e < 12; e++) tick();
    raw1 = 1'b1;
    for (int e = 0; e < 7; e++) tick();
    total++;
    if (ss1_channel_up !== 1'b0 || ss0_channel_up !== 1'b1)
      $display("FAIL reset_mid_setup got up1=%b up0=%b expected up1=0 up0=1", ss1_channel_up, ss0_channel_up);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total++;
    if (obs !== 14'd0) $display("FAIL reset_mid_outputs got %h expected %h", obs, 14'd0);
    else pass_cnt++;
    reset = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      total++;
      if (ss1_channel_up !== (e >= 10) || ss0_channel_up !== (e >= 10))
        $display("FAIL reset_mid_relatch edge %0d got up1=%b up0=%b expected %b", e, ss1_channel_up, ss0_channel_up, e >= 10);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int hold0 = 0, hold1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold0 == 0) begin raw0 = 1'($urandom); hold0 = $urandom_range(1, 14); end
      if (hold1 == 0) begin raw1 = 1'($urandom); hold1 = $urandom_range(1, 14); end
      hold0--;
      hold1--;
      clear_stats = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (obs !== exp_vec()) $display("FAIL random_model cycle %0d got %h expected %h", c, obs, exp_vec());
      else pass_cnt++;
    end
    clear_stats = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_drop();
    test_saturate();
    test_clear_coincide();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
